// File: rtl/pulse_timer.sv
// Pulse-width timer: timestamps each high pulse on sig_in and queues {start, width, sat} in a 2-deep FIFO.
// Record pushed on the fall edge, visible the next cycle; out_ready backpressure; a push into a full FIFO with no pop is dropped and counted.
module pulse_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] timestamp,
    input  logic       sig_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_start,
    output logic [7:0] out_width,
    output logic       out_sat,
    output logic [7:0] drop_cnt
);

    typedef enum logic {IDLE, HIGH} state_t;

    typedef struct packed {
        logic [7:0] start;
        logic [7:0] width;
        logic       sat;
    } rec_t;

    state_t     state_q, state_d;
    logic       sig_prev_q, sig_prev_d;
    logic [7:0] start_ts_q, start_ts_d;
    logic [7:0] run_cnt_q, run_cnt_d;
    logic       long_q, long_d;
    rec_t       head_q, head_d;
    rec_t       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic [7:0] drop_q, drop_d;

    logic       push;
    logic       pop;
    logic [1:0] occ;
    rec_t       rec;

    always_comb begin
        state_d    = state_q;
        sig_prev_d = sig_in;
        start_ts_d = start_ts_q;
        run_cnt_d  = run_cnt_q;
        long_d     = long_q;
        push       = 1'b0;

        // Modular subtraction gives the right width even when the pulse spans the timestamp wrap.
        rec.start = start_ts_q;
        rec.width = long_q ? 8'hFF : (timestamp - start_ts_q);
        rec.sat   = long_q;

        case (state_q)
            IDLE: begin
                if (sig_in && !sig_prev_q) begin
                    state_d    = HIGH;
                    start_ts_d = timestamp;
                    run_cnt_d  = 8'd1;
                    long_d     = 1'b0;
                end
            end
            HIGH: begin
                if (sig_in) begin
                    if (run_cnt_q == 8'hFF) begin
                        long_d = 1'b1;
                    end else begin
                        run_cnt_d = run_cnt_q + 8'd1;
                    end
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pop is applied first so a push into a full FIFO with a simultaneous pop still lands.
        pop     = (count_q != 2'd0) && out_ready;
        occ     = count_q - {1'b0, pop};
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = occ;
        drop_d  = drop_q;

        if (pop) begin
            head_d = tail_q;
        end

        if (push) begin
            if (occ == 2'd0) begin
                head_d  = rec;
                count_d = 2'd1;
            end else if (occ == 2'd1) begin
                tail_d  = rec;
                count_d = 2'd2;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sig_prev_q <= 1'b1;
            start_ts_q <= 8'd0;
            run_cnt_q  <= 8'd0;
            long_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            sig_prev_q <= sig_prev_d;
            start_ts_q <= start_ts_d;
            run_cnt_q  <= run_cnt_d;
            long_q     <= long_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_start = head_q.start;
    assign out_width = head_q.width;
    assign out_sat   = head_q.sat;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pulse_timer.sv
// Scoreboard bench for pulse_timer: expected records queued as pulses are driven, checked as the DUT pops them.
module tb_pulse_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ts = 8'd0;
    logic       sig_in = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_start;
    logic [7:0] out_width;
    logic       out_sat;
    logic [7:0] drop_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_drop = 0;
    logic [16:0] sb_q[$];
    logic [16:0] exp_rec;
    logic [16:0] held;
    logic        hold = 1'b0;

    pulse_timer dut (
        .clk       (clk),
        .rst       (rst),
        .timestamp (ts),
        .sig_in    (sig_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_start (out_start),
        .out_width (out_width),
        .out_sat   (out_sat),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Timestamp source: advances once per clock, in step with every tick.
    task automatic tick();
        @(posedge clk);
        #1;
        ts = ts + 8'd1;
    endtask

    task automatic wait_ts(input logic [7:0] v);
        for (int i = 0; i < 300 && ts != v; i++) tick();
    endtask

    // Leaves sig_in low for the fall cycle; the caller issues the tick that samples the fall.
    task automatic pulse(input logic [7:0] st, input int n, input bit keep);
        logic [7:0] w;
        logic       s;
        wait_ts(st);
        sig_in = 1'b1;
        repeat (n) tick();
        sig_in = 1'b0;
        s = (n >= 256);
        w = s ? 8'hFF : 8'(n);
        if (keep) sb_q.push_back({st, w, s});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        chk(tag, sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_vld", int'(out_valid), 1);
                chk("hold_dat", int'({out_start, out_width, out_sat}), int'(held));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rec", int'({out_start, out_width, out_sat}), 0);
                end else begin
                    exp_rec = sb_q.pop_front();
                    chk("rec", int'({out_start, out_width, out_sat}), int'(exp_rec));
                end
            end
            hold = out_valid && !out_ready;
            held = {out_start, out_width, out_sat};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sig_in = 1'b0;
        tick();
        tick();
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_start", int'(out_start), 0);
        chk("rst_width", int'(out_width), 0);
        chk("rst_sat", int'(out_sat), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        rst = 1'b0;

        // Basic pulse with one-cycle output latency.
        out_ready = 1'b1;
        pulse(8'd10, 5, 1'b1);
        chk("pre_fall_vld", int'(out_valid), 0);
        tick();
        chk("post_fall_vld", int'(out_valid), 1);
        tick();

        // Timestamp wrap, long pulses, minimum pulse and gap.
        pulse(8'd250, 10, 1'b1);
        tick();
        pulse(8'd100, 255, 1'b1);
        tick();
        pulse(8'd120, 300, 1'b1);
        tick();
        pulse(8'd170, 1, 1'b1);
        tick();
        pulse(ts, 2, 1'b1);
        tick();
        drain("drain_basic");

        // Backpressure: third record finds the FIFO full and is dropped.
        out_ready = 1'b0;
        pulse(8'd20, 3, 1'b1);
        tick();
        pulse(8'd30, 3, 1'b1);
        tick();
        pulse(8'd40, 3, 1'b0);
        tick();
        exp_drop++;
        chk("bp_drop", int'(drop_cnt), exp_drop);
        out_ready = 1'b1;
        drain("drain_bp");
        tick();
        chk("bp_idle_vld", int'(out_valid), 0);

        // Push and pop in the same cycle on a full FIFO.
        out_ready = 1'b0;
        pulse(8'd50, 3, 1'b1);
        tick();
        pulse(8'd60, 3, 1'b1);
        tick();
        pulse(8'd70, 3, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("full_pp_drop", int'(drop_cnt), exp_drop);
        chk("full_pp_vld", int'(out_valid), 1);
        out_ready = 1'b1;
        drain("drain_full_pp");

        // sig_in high through reset release is ignored until seen low.
        rst = 1'b1;
        sig_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_drop = 0;
        repeat (20) tick();
        chk("rst_hi_vld", int'(out_valid), 0);
        sig_in = 1'b0;
        tick();
        chk("rst_hi_drop", int'(drop_cnt), exp_drop);
        pulse(8'd90, 4, 1'b1);
        tick();
        drain("drain_rst_hi");

        // Reset mid-pulse with a record pending discards everything.
        out_ready = 1'b0;
        pulse(8'd100, 3, 1'b0);
        tick();
        sig_in = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        sig_in = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_vld", int'(out_valid), 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("mid_rst_idle", int'(out_valid), 0);

        pulse(8'd130, 7, 1'b1);
        tick();
        drain("drain_final");
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
